// File: rtl/mcs4_pkg.sv
// Shared MCS-4 debug-port types and host-command opcodes.
package mcs4;

  typedef logic [3:0] char_t;
  typedef logic [7:0] byte_t;
  typedef char_t [2:0] dbg_addr_t;

  localparam byte_t DBG_OP_WR  = 8'h01;
  localparam byte_t DBG_OP_RD  = 8'h02;
  localparam byte_t DBG_OP_BWR = 8'h03;

endpackage

// File: rtl/dbg_host.sv
// Debug-bus initiator: decodes a byte-serial command stream into MCS-4 debug
// port reads/writes and returns ack, error or read data on a response stream.
module dbg_host
  import mcs4::*;
#(
  parameter int    RD_LATENCY = 1,
  parameter byte_t ACK_BYTE   = 8'hA5,
  parameter byte_t ERR_BYTE   = 8'hEE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [7:0]        resp_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output mcs4::char_t [2:0] dbg_addr,
  output mcs4::byte_t       dbg_wdata,
  output logic              dbg_wen,
  input  mcs4::byte_t       dbg_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, COUNT, DATA, WRITE, RD_WAIT, RESP
  } state_t;

  state_t    state_reg, state_next;
  byte_t     op_reg, op_next;
  char_t     addr_hi_reg, addr_hi_next;
  dbg_addr_t addr_reg, addr_next;
  byte_t     wdata_reg, wdata_next;
  byte_t     remain_reg, remain_next;
  logic [1:0] wait_reg, wait_next;
  byte_t     resp_data_reg, resp_data_next;
  logic      resp_valid_reg, resp_valid_next;
  logic      cmd_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      op_reg         <= '0;
      addr_hi_reg    <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      remain_reg     <= '0;
      wait_reg       <= '0;
      resp_data_reg  <= '0;
      resp_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      op_reg         <= op_next;
      addr_hi_reg    <= addr_hi_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      remain_reg     <= remain_next;
      wait_reg       <= wait_next;
      resp_data_reg  <= resp_data_next;
      resp_valid_reg <= resp_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    addr_hi_next    = addr_hi_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    remain_next     = remain_reg;
    wait_next       = wait_reg;
    resp_data_next  = resp_data_reg;
    resp_valid_next = resp_valid_reg;
    cmd_ready       = (state_reg == IDLE) || (state_reg == ADDR_HI) ||
                      (state_reg == ADDR_LO) || (state_reg == COUNT) ||
                      (state_reg == DATA);
    cmd_fire        = cmd_valid && cmd_ready;

    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          op_next = cmd_data;
          if (cmd_data == DBG_OP_WR || cmd_data == DBG_OP_RD || cmd_data == DBG_OP_BWR) begin
            state_next = ADDR_HI;
          end else begin
            resp_data_next  = ERR_BYTE;
            resp_valid_next = 1'b1;
            state_next      = RESP;
          end
        end
      end
      ADDR_HI: begin
        if (cmd_fire) begin
          addr_hi_next = cmd_data[3:0];
          state_next   = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (cmd_fire) begin
          addr_next   = {addr_hi_reg, cmd_data[7:4], cmd_data[3:0]};
          remain_next = 8'd1;
          wait_next   = '0;
          if (op_reg == DBG_OP_WR)      state_next = DATA;
          else if (op_reg == DBG_OP_RD) state_next = RD_WAIT;
          else                          state_next = COUNT;
        end
      end
      COUNT: begin
        // A count of zero decrements through 255 and so yields 256 writes.
        if (cmd_fire) begin
          remain_next = cmd_data;
          state_next  = DATA;
        end
      end
      DATA: begin
        if (cmd_fire) begin
          wdata_next = cmd_data;
          state_next = WRITE;
        end
      end
      WRITE: begin
        remain_next = remain_reg - 8'd1;
        if (op_reg == DBG_OP_BWR) addr_next = dbg_addr_t'(addr_reg + 12'd1);
        if (remain_reg == 8'd1) begin
          resp_data_next  = ACK_BYTE;
          resp_valid_next = 1'b1;
          state_next      = RESP;
        end else begin
          state_next = DATA;
        end
      end
      RD_WAIT: begin
        if (wait_reg == 2'(RD_LATENCY)) begin
          resp_data_next  = dbg_rdata;
          resp_valid_next = 1'b1;
          state_next      = RESP;
        end else begin
          wait_next = wait_reg + 2'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dbg_addr   = addr_reg;
  assign dbg_wdata  = wdata_reg;
  assign dbg_wen    = (state_reg == WRITE);
  assign resp_data  = resp_data_reg;
  assign resp_valid = resp_valid_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: doc/dbg_host.md
Name: dbg_host

Overview:
- Debug-bus initiator: turns a byte-serial command stream (host UART/AXI-stream side) into transactions on the MCS-4 debug port (dbg_addr/dbg_wdata/dbg_wen/dbg_rdata) consumed by dbg_ctl.
- Returns acknowledgements and read data on a byte-serial response stream.
- Used for ROM loading, reset control and CPU state readback without a processor on the host side.

Parameters:
- RD_LATENCY, 1, cycles from dbg_addr presented (dbg_wen=0) to dbg_rdata being valid; legal range 0..3.
- ACK_BYTE, 8'hA5, response byte on successful write or burst-write completion.
- ERR_BYTE, 8'hEE, response byte on unknown opcode.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cmd_data  input  8  command stream byte.
- cmd_valid  input  1  cmd_data valid.
- cmd_ready  output  1  block accepts cmd_data this cycle.
- resp_data  output  8  response byte.
- resp_valid  output  1  resp_data valid.
- resp_ready  input  1  downstream accepts resp_data.
- dbg_addr  output  3x4 (mcs4::char_t [2:0])  debug address; [2] is the most significant char.
- dbg_wdata  output  8 (mcs4::byte_t)  debug write data.
- dbg_wen  output  1  single-cycle write strobe.
- dbg_rdata  input  8 (mcs4::byte_t)  debug read data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (one clk edge with rst=1): state=IDLE; dbg_addr=0, dbg_wdata=0, dbg_wen=0, resp_valid=0, resp_data=0, cmd_ready=1, busy=0. A partial frame or pending response is discarded; no dbg_wen is issued after reset.
- Byte transfer on cmd occurs when cmd_valid && cmd_ready. Transfer on resp occurs when resp_valid && resp_ready.
- cmd_ready=1 only in IDLE, ADDR_HI, ADDR_LO, COUNT and DATA.
- Frames (first byte is the opcode):
  - 0x01 WR: addr_hi, addr_lo, data.
  - 0x02 RD: addr_hi, addr_lo.
  - 0x03 BWR: addr_hi, addr_lo, count, then count data bytes; count=0 means 256 bytes.
  - Any other opcode: go directly to RESP with ERR_BYTE. No debug access occurs.
- Address is 12 bits: {addr_hi[3:0], addr_lo}. addr_hi[7:4] is ignored. dbg_addr[2]=addr_hi[3:0], dbg_addr[1]=addr_lo[7:4], dbg_addr[0]=addr_lo[3:0].
- dbg_addr is registered and updates when addr_lo is accepted.
- State machine: IDLE -> ADDR_HI -> ADDR_LO -> {DATA (WR) | RD_WAIT (RD) | COUNT (BWR)}.
  - COUNT -> DATA.
  - DATA -> WRITE.
  - WRITE -> DATA if burst bytes remain, else RESP.
  - RD_WAIT -> RESP.
  - RESP -> IDLE when resp_ready is seen.
- WRITE:
  - Data byte accepted on edge T: dbg_wdata is registered; dbg_wen=1 for exactly the cycle after T; dbg_addr is stable throughout.
  - In BWR, dbg_addr increments by 1 after each write, wrapping 0xFFF->0x000. The 8-bit remaining counter decrements once per write.
  - Minimum burst throughput: one byte per 2 cycles.
- RD_WAIT: dbg_addr is held with dbg_wen=0. dbg_rdata is sampled RD_LATENCY cycles after entry; RD_LATENCY=0 samples in the entry cycle. The sampled value becomes resp_data.
- RESP: resp_valid=1 with resp_data held stable until accepted; cmd_ready=0 throughout.
  - WR/BWR respond ACK_BYTE; the write-completion response is valid the cycle after dbg_wen.
  - RD responds with the read data.
- Stalls: cmd_valid=0 mid-frame holds state indefinitely (no timeout). resp_ready=0 holds RESP indefinitely.
- dbg_wen is never asserted outside WRITE and never for two consecutive cycles.

Decomposition:
- Shared mcs4 package:
  - opcode constants DBG_OP_WR/RD/BWR;
  - dbg_addr_t (12-bit packed, or char_t [2:0]);
  - existing char_t/byte_t.
- FSM state enum stays local to the module.
- No sub-module needed. An optional 2-entry skid on resp is not required.

Test Plan:
- WR: cmd 01,0F,23,5A -> one dbg_wen pulse with dbg_addr={F,2,3}, dbg_wdata=5A; then resp A5.
- RD with dbg_rdata model returning addr[7:0]^8'h3C: cmd 02,01,10 -> no dbg_wen; resp 2C. Repeat with RD_LATENCY=0 and RD_LATENCY=3.
- BWR wrap: cmd 03,0F,FE,03,11,22,33 -> writes 11@FFE, 22@FFF, 33@000; exactly 3 wen pulses; resp A5. count=00 -> 256 writes.
- Bad opcode 0x7F -> resp EE, no wen, next frame (WR) processes normally. cmd_valid gaps mid-frame and resp_ready=0 for 10 cycles -> data integrity held, resp_data stable.
- rst asserted after BWR data byte 2 of 4 -> outputs return to reset values next cycle, no further wen, no resp; a following WR frame works.
